// File: rtl/axicb_scfifo_pkg.sv
// Shared constants for the crossbar channel FIFO.
package axicb_scfifo_pkg;

  // Read-path selection values for the FFD_EN parameter.
  localparam int FFD_COMB = 0;
  localparam int FFD_REG  = 1;

endpackage

// File: rtl/axicb_scfifo_regfile.sv
// Storage array for axicb_scfifo: one write port and one read port.
// With FFD_EN=1 the read data is registered, so data_out shows the word
// addressed in the previous cycle. Reset clears every entry.
module axicb_scfifo_regfile
  import axicb_scfifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FFD_EN     = 0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] addr_out,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] ram [DEPTH];

  // Write port; reset clears contents so a freshly reset FIFO reads zero.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else if (srst) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else if (wr_en) begin
      ram[addr_in] <= data_in;
    end
  end

  generate
    if (FFD_EN == FFD_REG) begin : g_reg_read
      logic [DATA_WIDTH-1:0] data_q;

      // Registered read: samples the array before this edge's write lands.
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          data_q <= '0;
        end else if (srst) begin
          data_q <= '0;
        end else begin
          data_q <= ram[addr_out];
        end
      end

      assign data_out = data_q;
    end else begin : g_comb_read
      assign data_out = ram[addr_out];
    end
  endgenerate

endmodule

// File: rtl/axicb_scfifo.sv
// Single-clock valid/ready FIFO for crossbar channel buffering.
// Keeps wrap-extended read/write pointers, derives occupancy and flags,
// and presents the head word first-word-fall-through in both read modes.
module axicb_scfifo
  import axicb_scfifo_pkg::*;
#(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int FFD_EN        = 0,
  parameter int AFULL_THRESH  = (2**ADDR_WIDTH) - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  afull,
  output logic                  aempty
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      rd_ptr_next;
  logic [PTR_W-1:0]      pop_ext;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] addr_out;

  assign push    = in_valid & in_ready;
  assign pop     = out_valid & out_ready;
  assign pop_ext = {{ADDR_WIDTH{1'b0}}, pop};

  // Extra pointer bit lets the modulo difference distinguish full from empty.
  assign count       = wr_ptr - rd_ptr;
  assign rd_ptr_next = rd_ptr + pop_ext;

  assign full     = (count == PTR_W'(DEPTH));
  assign empty    = (count == '0);
  assign afull    = (count >= PTR_W'(AFULL_THRESH));
  assign aempty   = (count <= PTR_W'(AEMPTY_THRESH));
  assign in_ready = !full;

  // Pointer advance on accepted handshakes; reset drops all contents.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  generate
    if (FFD_EN == FFD_REG) begin : g_ffd
      logic valid_q;

      // Read one slot ahead so the output register always holds ram[rd_ptr].
      assign addr_out = rd_ptr_next[ADDR_WIDTH-1:0];

      // Valid only counts words already in RAM before this edge, so a word
      // written into the slot being prefetched is shown one cycle later.
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          valid_q <= 1'b0;
        end else if (srst) begin
          valid_q <= 1'b0;
        end else begin
          valid_q <= ((count - pop_ext) != '0);
        end
      end

      assign out_valid = valid_q;
    end else begin : g_comb
      assign addr_out  = rd_ptr[ADDR_WIDTH-1:0];
      assign out_valid = !empty;
    end
  endgenerate

  axicb_scfifo_regfile #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .FFD_EN     (FFD_EN)
  ) u_regfile (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .srst     (srst),
    .wr_en    (push),
    .addr_in  (wr_ptr[ADDR_WIDTH-1:0]),
    .data_in  (in_data),
    .addr_out (addr_out),
    .data_out (out_data)
  );

endmodule
